stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Drives the 4-digit, common-anode seven-segment display from the stopwatch's BCD time digits (minutes tens/units, seconds tens/units). It sits directly downstream of the stopwatch counter. It time-multiplexes one digit at a time, decodes each digit to segments, lights the minutes/seconds separator, and blinks the selected digit pair while the stopwatch is in adjust mode. All outputs are registered, and the block runs on the single system clock.

## Interface
- REFRESH_DIV, default 100000: system-clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- BLINK_DIV, default 250: refresh ticks per blink half-period (2 Hz blink at defaults); minimum 1.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- min_ten  in  3  minutes tens digit, 0-7.
- min_unit  in  4  minutes units digit, 0-15.
- sec_ten  in  3  seconds tens digit, 0-7.
- sec_unit  in  4  seconds units digit, 0-15.
- adjust  in  1  1 = adjust mode; the selected pair blinks.
- sel  in  1  pair to blink: 0 = seconds (digits 1,0), 1 = minutes (digits 3,2).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low; an[0] = sec_unit (rightmost), an[3] = min_ten.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = 1 in the cycle where the prescaler equals REFRESH_DIV-1.
- Digit index (2 bits):
  - Advances on tick: 0→1→2→3→0.
  - Digit 0 = sec_unit, 1 = sec_ten, 2 = min_unit, 3 = min_ten.
- Snapshot:
  - The four input digits are captured into an internal snapshot on the edge where tick=1 and index=3 (the frame boundary).
  - The display always shows the snapshot, so one frame never mixes two counter values.
- Blink:
  - A blink counter counts ticks from 0 to BLINK_DIV-1.
  - On the tick where it equals BLINK_DIV-1, it wraps and blink_phase toggles.
  - The blink counter and blink_phase run whether or not adjust is set.
- Blanking: the current digit is blank (an all 1, seg all 1) when adjust=1, blink_phase=1, and the current digit belongs to the pair chosen by sel.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value 10-15 shows a dash: 0111111.
  - Three-bit inputs are zero-extended before decode.
- Anodes: when not blanked, exactly one anode is low, selected by index.
- Decimal point:
  - dp=0 only when index=2 and the digit is not blanked; dp=1 otherwise.
  - This places the separator between minutes and seconds.

## Timing
- Reset values:
  - an=1111, seg=1111111, dp=1.
  - Prescaler, index, blink counter and blink_phase = 0; snapshot = all zeros.
- Output latency:
  - seg/an/dp are registered from the current index, snapshot, adjust, sel and blink_phase.
  - They reflect a change in any of these exactly one cycle later.
  - First edge after reset deasserts: an=1110, seg=1000000.
- Input latency:
  - Input values are displayed starting at the frame after the capture edge.
  - Worst-case latency is 4·REFRESH_DIV+1 cycles.
- adjust and sel are not snapshotted. A change takes effect on the next output register update, even mid-frame.
- Simultaneous events: on the edge where tick=1 and index=3, the snapshot load, the index wrap to 0 and any blink toggle all happen together.
- Reset asserted mid-operation: on that edge, all state returns to its reset values and any partially displayed frame is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: digit 3 is blanked whenever the snapshot min_ten = 0 (an[3] stays high, seg=1111111). Digits 2..0 are never suppressed.
  - Undefined: min_ten = 0 displays "0" like any other digit.
  - Blink blanking applies in both builds.

## Test plan
- Reset and scan (REFRESH_DIV=4):
  - Hold reset 3 cycles, then release.
  - an must cycle 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg must equal 1000000 throughout the first frame.
  - dp must be 0 only while an=1011.
- Snapshot (inputs set to 5,9,4,2 = 59:42 mid-frame):
  - The current frame must still show 00:00.
  - The next frame must show digit 3=0010010, 2=0010000, 1=0011001, 0=0100100.
- Tear-free update: change the inputs every 3 cycles. Each displayed frame must equal the input value present at its preceding capture edge.
- Blink (BLINK_DIV=2, adjust=1, sel=1):
  - The minutes anodes must be dark for 2 ticks, then lit for 2 ticks, alternating.
  - The seconds digits must scan normally.
  - Switching to sel=0 must move the blanking to an[1:0] on the next output update.
- Dash and leading zero:
  - min_unit=12 must give seg=0111111 on digit 2.
  - min_ten=0 must blank an[3] with LEADING_ZERO_BLANK_EN defined and show 1000000 without it.
- Mid-frame reset: assert reset while index=2. On the next edge, outputs must be an=1111, seg=1111111, dp=1, and the scan must restart at digit 0.

Source files
------------

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - 4-digit multiplexed seven-segment driver for stopwatch BCD time.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses a zero minutes-tens digit.
module stopwatch_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] min_ten,
    input  logic [3:0] min_unit,
    input  logic [2:0] sec_ten,
    input  logic [3:0] sec_unit,
    input  logic       adjust,
    input  logic       sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic [2:0]    snap_mt;
    logic [3:0]    snap_mu;
    logic [2:0]    snap_st;
    logic [3:0]    snap_su;
    logic          tick;
    logic [3:0]    cur_digit;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = (presc == PW'(REFRESH_DIV - 1));

    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            2'd0: cur_digit = snap_su;
            2'd1: cur_digit = {1'b0, snap_st};
            2'd2: cur_digit = snap_mu;
            2'd3: cur_digit = {1'b0, snap_mt};
            default: cur_digit = 4'd0;
        endcase
    end

    // idx[1] set means a minutes digit, which lines up with sel=1
    always_comb begin
        blank = adjust & phase & (sel == idx[1]);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && snap_mt == 3'd0)
            blank = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc   <= '0;
            idx     <= 2'd0;
            bcnt    <= '0;
            phase   <= 1'b0;
            snap_mt <= 3'd0;
            snap_mu <= 4'd0;
            snap_st <= 3'd0;
            snap_su <= 4'd0;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
                if (bcnt == BW'(BLINK_DIV - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
                // frame boundary: new time takes effect from digit 0 onwards
                if (idx == 2'd3) begin
                    snap_mt <= min_ten;
                    snap_mu <= min_unit;
                    snap_st <= sec_ten;
                    snap_su <= sec_unit;
                end
            end
            if (blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= decode(cur_digit);
                dp  <= (idx != 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - directed checks of stopwatch_display scan, snapshot, blink and reset.
// Honours LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_stopwatch_display;

    localparam int RD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] min_ten = 3'd0;
    logic [3:0] min_unit = 4'd0;
    logic [2:0] sec_ten = 3'd0;
    logic [3:0] sec_unit = 4'd0;
    logic       adjust = 1'b0;
    logic       sel = 1'b0;
    logic [6:0] seg, seg_b3;
    logic [3:0] an, an_b3;
    logic       dp, dp_b3;

    int vec_count = 0;
    int err_count = 0;

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(2)) dut (
        .clock(clock), .reset(reset), .min_ten(min_ten), .min_unit(min_unit),
        .sec_ten(sec_ten), .sec_unit(sec_unit), .adjust(adjust), .sel(sel),
        .seg(seg), .an(an), .dp(dp)
    );

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_DIV(3)) dut_b3 (
        .clock(clock), .reset(reset), .min_ten(min_ten), .min_unit(min_unit),
        .sec_ten(sec_ten), .sec_unit(sec_unit), .adjust(adjust), .sel(sel),
        .seg(seg_b3), .an(an_b3), .dp(dp_b3)
    );

    always #5 clock = ~clock;

    logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    typedef struct {
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        logic [6:0] s3, s2, s1, s0;
    } vec_t;

    vec_t tv [5];

    // expected {an,seg,dp} for the output produced by the k-th edge after reset release
    function automatic logic [11:0] model(input int k, input int bd, input logic [15:0] dig,
                                          input logic adj, input logic sl);
        int j, idx, ph;
        logic [3:0] d;
        logic bl;
        j   = k - 1;
        idx = (j / RD) % 4;
        ph  = ((j / RD) / bd) % 2;
        d   = dig[idx*4 +: 4];
        bl  = adj && (ph == 1) && (sl == (idx >= 2));
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 3 && d == 4'd0) bl = 1'b1;
`endif
        if (bl) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << idx), dec_tab[d], (idx != 2)};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic set_inputs(input logic [15:0] dig);
        min_ten  = dig[14:12];
        min_unit = dig[11:8];
        sec_ten  = dig[6:4];
        sec_unit = dig[3:0];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_state", {an, seg, dp}, 12'hFFF);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] gen(input int n);
        logic [15:0] r;
        r = {1'b0, 3'(1 + n % 7), 4'(n % 10), 1'b0, 3'(n % 6), 4'((n * 7) % 10)};
        return r;
    endfunction

    initial begin
        logic [15:0] cap [4];
        logic [15:0] cur;
        logic [6:0]  es;
        int d, n;
        logic sl_k;

        tv[0] = '{3'd5, 4'd9,  3'd4, 4'd2,  7'h12, 7'h10, 7'h19, 7'h24};
        tv[1] = '{3'd1, 4'd3,  3'd6, 4'd7,  7'h79, 7'h30, 7'h02, 7'h78};
        tv[2] = '{3'd7, 4'd8,  3'd0, 4'd1,  7'h78, 7'h00, 7'h40, 7'h79};
        tv[3] = '{3'd2, 4'd12, 3'd5, 4'd15, 7'h24, 7'h3F, 7'h12, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
        tv[4] = '{3'd0, 4'd10, 3'd3, 4'd11, 7'h7F, 7'h3F, 7'h30, 7'h3F};
`else
        tv[4] = '{3'd0, 4'd10, 3'd3, 4'd11, 7'h40, 7'h3F, 7'h30, 7'h3F};
`endif

        // scan after reset, then mid-frame input change appears one frame later
        set_inputs(16'h0000);
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            check($sformatf("scan_k%0d", k), {an, seg, dp},
                  model(k, 2, (k <= 16) ? 16'h0000 : 16'h5942, 1'b0, 1'b0));
            if (k == 6) set_inputs(16'h5942);
        end

        // decode table, including dashes and a zero minutes-tens
        for (int v = 0; v < 5; v++) begin
            min_ten = tv[v].mt; min_unit = tv[v].mu; sec_ten = tv[v].st; sec_unit = tv[v].su;
            do_reset();
            for (int k = 1; k <= 32; k++) begin
                @(negedge clock);
                if (k > 16 && (k - 1) % RD == 0) begin
                    d = ((k - 1) / RD) % 4;
                    case (d)
                        0: es = tv[v].s0;
                        1: es = tv[v].s1;
                        2: es = tv[v].s2;
                        default: es = tv[v].s3;
                    endcase
                    check($sformatf("table_v%0d_d%0d", v, d), {an, seg, dp},
                          (es == 7'h7F) ? 12'hFFF : {~(4'b0001 << d), es, (d != 2)});
                end
            end
        end

        // tear-free: inputs change every 3 cycles, frames show the capture-edge value
        n = 0;
        cur = gen(n);
        set_inputs(cur);
        do_reset();
        cap[0] = 16'h0000;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            if ((k - 1) % RD == 0)
                check($sformatf("tear_k%0d", k), {an, seg, dp},
                      model(k, 2, cap[(k - 1) / 16], 1'b0, 1'b0));
            if (k % 16 == 0 && k < 64) cap[k / 16] = cur;
            if (k % 3 == 0) begin
                n++;
                cur = gen(n);
                set_inputs(cur);
            end
        end

        // blink on minutes, then switch to seconds mid-run
        adjust = 1'b1;
        sel = 1'b1;
        set_inputs(16'h1234);
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            @(negedge clock);
            sl_k = (k >= 25) ? 1'b0 : 1'b1;
            check($sformatf("blink2_k%0d", k), {an, seg, dp},
                  model(k, 2, (k <= 16) ? 16'h0000 : 16'h1234, 1'b1, sl_k));
            check($sformatf("blink3_k%0d", k), {an_b3, seg_b3, dp_b3},
                  model(k, 3, (k <= 16) ? 16'h0000 : 16'h1234, 1'b1, sl_k));
            if (k == 24) sel = 1'b0;
        end
        adjust = 1'b0;

        // reset while digit 2 is being scanned clears outputs and snapshot
        set_inputs(16'h5942);
        do_reset();
        repeat (26) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_out", {an, seg, dp}, 12'hFFF);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check($sformatf("restart_k%0d", k), {an, seg, dp}, model(k, 2, 16'h0000, 1'b0, 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
